// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Lets NUM_REQ independent byte sources share one UART transmitter byte
// interface. Ownership rotates round-robin and a granted requester keeps the
// transmitter until it sends a byte flagged last, drops its valid, or has sent
// MAX_BURST bytes.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog that aborts a
// byte whose tx_done_i does not arrive within TIMEOUT_CYCLES cycles of WAIT.
// Without the macro, err_timeout_o is tied low and WAIT has no time limit.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_done_i,
    output logic                   busy_o,
    output logic                   err_timeout_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    // Unsupported parameter values stop elaboration instead of building
    // hardware that silently misbehaves.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_badNumReq
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_badMaxBurst
        $error("uart_tx_arbiter: MAX_BURST must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_lastOwner;
    logic [BEAT_W-1:0]   r_beatCount;
    logic                r_lastFlag;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_txData;
    logic                r_txStart;

    logic                w_anyValid;
    logic [IDX_W-1:0]    w_pickIdx;
    logic [IDX_W-1:0]    w_cand;
    logic [BEAT_W-1:0]   w_beatNext;
    logic                w_doneSeen;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]     r_wdCount;
    logic                r_errTimeout;
`endif

    // Rotating-priority pick: scan from the lowest priority upward so the
    // requester right after the previous owner wins when several are valid.
    always_comb begin
        w_anyValid = 1'b0;
        w_pickIdx  = '0;
        w_cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = IDX_W'((int'(r_lastOwner) + i) % NUM_REQ);
            if (req_valid_i[w_cand]) begin
                w_anyValid = 1'b1;
                w_pickIdx  = w_cand;
            end
        end
    end

    // A done pulse that coincides with our own start pulse belongs to no byte
    // of ours, so it is masked out here.
    always_comb begin
        w_doneSeen = tx_done_i && !r_txStart;
        w_beatNext = r_beatCount + BEAT_W'(1);
    end

    // Main FSM: arbitration in IDLE, byte capture in LOAD, completion and
    // burst accounting in WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_lastOwner  <= IDX_W'(NUM_REQ - 1);
            r_beatCount  <= '0;
            r_lastFlag   <= 1'b0;
            r_grant      <= '0;
            r_txData     <= 8'h00;
            r_txStart    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdCount    <= '0;
            r_errTimeout <= 1'b0;
`endif
        end else begin
            r_txStart    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_errTimeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_anyValid) begin
                        r_owner     <= w_pickIdx;
                        r_grant     <= NUM_REQ'(1) << w_pickIdx;
                        r_beatCount <= '0;
                        r_state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (req_valid_i[r_owner]) begin
                        r_txData   <= req_data_i[{r_owner, 3'b000} +: 8];
                        r_lastFlag <= req_last_i[r_owner];
                        r_txStart  <= 1'b1;
                        r_state    <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                        r_wdCount  <= '0;
`endif
                    end else begin
                        r_lastOwner <= r_owner;
                        r_grant     <= '0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdCount <= r_wdCount + WD_W'(1);
`endif
                    if (w_doneSeen) begin
                        r_beatCount <= w_beatNext;
                        if (r_lastFlag || (w_beatNext == BEAT_W'(MAX_BURST))) begin
                            r_lastOwner <= r_owner;
                            r_grant     <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state     <= ST_LOAD;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_wdCount == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        r_errTimeout <= 1'b1;
                        r_lastOwner  <= r_owner;
                        r_grant      <= '0;
                        r_state      <= ST_IDLE;
                    end
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o     = r_grant;
    assign req_ready_o = (r_state == ST_LOAD) ? r_grant : '0;
    assign tx_data_o   = r_txData;
    assign tx_start_o  = r_txStart;
    assign busy_o      = (r_state != ST_IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    assign err_timeout_o = r_errTimeout;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
